// File: rtl/riscv_exc_arbiter_if.sv
// riscv_exc_arbiter_if
//   Handshake bundle between the exception arbiter and the main controller/CSR block.
//   master : arbiter side (drives request, cause, PC selects, trap and the cause strobe)
//   slave  : controller/CSR side (drives ack_i)
//   req_o        exception/IRQ request
//   ack_i        controller accepts the request
//   trap_o       debug trap request
//   pc_mux_o     exception PC select (EXC_PC_*)
//   vec_pc_mux_o vectored handler index (= cause_o[4:0])
//   cause_o      cause to CSR, bit5 = interrupt
//   save_cause_o CSR write strobe for cause_o
interface riscv_exc_arbiter_if;
    logic       req_o;
    logic       ack_i;
    logic       trap_o;
    logic [1:0] pc_mux_o;
    logic [4:0] vec_pc_mux_o;
    logic [5:0] cause_o;
    logic       save_cause_o;

    modport master (
        output req_o, trap_o, pc_mux_o, vec_pc_mux_o, cause_o, save_cause_o,
        input  ack_i
    );

    modport slave (
        input  req_o, trap_o, pc_mux_o, vec_pc_mux_o, cause_o, save_cause_o,
        output ack_i
    );
endinterface

// File: rtl/riscv_exc_arbiter.sv
// riscv_exc_arbiter
//   Exception/interrupt arbiter for the RI5CY pipeline. Synchronous exceptions win
//   over interrupts; among interrupts the lowest enabled pending id wins. Once a
//   request is raised and not accepted in the same cycle, its cause and PC select
//   are frozen until the controller acknowledges.
//
//   Build option: define RISCV_EXC_EDGE_IRQ_EN to honour IRQ_EDGE (rising-edge
//   pending latches per line). Without it every line is level-sensitive and
//   irq_pending_o mirrors irq_i.
//
// Ports
//   clk, rst         core clock, synchronous active-high reset
//   ctrl             controller handshake (req/ack, cause, pc_mux, vec_pc_mux, trap, save_cause)
//   irq_i            interrupt lines
//   irq_mask_i       per-line enable (1 = enabled)
//   irq_enable_i     global interrupt enable
//   ebrk_insn_i, illegal_insn_i, ecall_insn_i   decoder events
//   lsu_load_err_i, lsu_store_err_i             LSU bus errors
//   irq_pending_o    current pending vector
//   dbg_settings_i   debug settings (SSTE/EBRK/ELSU/EILL/ECALL/IRQ bits)
module riscv_exc_arbiter #(
    parameter int          NUM_IRQ    = 32,
    parameter logic [31:0] IRQ_EDGE   = 32'h0,
    parameter int          DBG_SETS_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    riscv_exc_arbiter_if.master   ctrl,
    input  logic [NUM_IRQ-1:0]    irq_i,
    input  logic [NUM_IRQ-1:0]    irq_mask_i,
    input  logic                  irq_enable_i,
    input  logic                  ebrk_insn_i,
    input  logic                  illegal_insn_i,
    input  logic                  ecall_insn_i,
    input  logic                  lsu_load_err_i,
    input  logic                  lsu_store_err_i,
    output logic [NUM_IRQ-1:0]    irq_pending_o,
    input  logic [DBG_SETS_W-1:0] dbg_settings_i
);

    // riscv_defines exception PC selects
    localparam logic [1:0] EXC_PC_ILLINSN = 2'b00;
    localparam logic [1:0] EXC_PC_ECALL   = 2'b01;
    localparam logic [1:0] EXC_PC_LOAD    = 2'b10;
    localparam logic [1:0] EXC_PC_STORE   = 2'b10;
    localparam logic [1:0] EXC_PC_IRQ     = 2'b11;

    // debug settings bit positions
    localparam int DBG_SETS_IRQ   = 5;
    localparam int DBG_SETS_ECALL = 4;
    localparam int DBG_SETS_EILL  = 3;
    localparam int DBG_SETS_ELSU  = 2;
    localparam int DBG_SETS_EBRK  = 1;
    localparam int DBG_SETS_SSTE  = 0;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_ACK = 2'b01
    } state_e;

    state_e       state;
    logic [5:0]   cause_q;
    logic [1:0]   pc_mux_q;

    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] eff;
    logic [4:0]         irq_id;
    logic               irq_any;
    logic [5:0]         cause_int;
    logic [1:0]         pc_mux_int;
    logic               req_int;
    logic [5:0]         cause_sel;

    // ------------------------------------------------------------------
    // Pending vector
    // ------------------------------------------------------------------
`ifdef RISCV_EXC_EDGE_IRQ_EN
    // Handshake and the cause being accepted on that cycle: the freshly
    // arbitrated one in IDLE (one-cycle handshake), the frozen one otherwise.
    logic       hs;
    logic [5:0] hs_cause;
    assign hs       = ctrl.req_o & ctrl.ack_i;
    assign hs_cause = (state == WAIT_ACK) ? cause_q : cause_int;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_lane
        if (IRQ_EDGE[g]) begin : g_edge
            logic pend_q;
            logic irq_d;
            logic clr;
            assign clr = hs & hs_cause[5] & (hs_cause[4:0] == 5'(g));
            always_ff @(posedge clk) begin
                if (rst) begin
                    pend_q <= 1'b0;
                    irq_d  <= 1'b0;
                end else begin
                    irq_d  <= irq_i[g];
                    // a new rising edge in the clearing cycle keeps the line pending
                    pend_q <= (irq_i[g] & ~irq_d) | (pend_q & ~clr);
                end
            end
            assign pend[g] = pend_q;
        end else begin : g_level
            assign pend[g] = irq_i[g];
        end
    end
`else
    assign pend = irq_i;
    logic unused_cfg;
    assign unused_cfg = ^IRQ_EDGE;
`endif

    assign irq_pending_o = pend;
    assign eff           = pend & irq_mask_i & {NUM_IRQ{irq_enable_i}};
    assign irq_any       = |eff;

    // lowest set index wins
    always_comb begin
        irq_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eff[i]) irq_id = 5'(i);
        end
    end

    // ------------------------------------------------------------------
    // Priority arbitration
    // ------------------------------------------------------------------
    always_comb begin
        cause_int  = 6'h00;
        pc_mux_int = EXC_PC_ILLINSN;
        if (lsu_store_err_i) begin
            cause_int  = 6'h07;
            pc_mux_int = EXC_PC_STORE;
        end else if (lsu_load_err_i) begin
            cause_int  = 6'h05;
            pc_mux_int = EXC_PC_LOAD;
        end else if (illegal_insn_i) begin
            cause_int  = 6'h02;
            pc_mux_int = EXC_PC_ILLINSN;
        end else if (ecall_insn_i) begin
            cause_int  = 6'h0B;
            pc_mux_int = EXC_PC_ECALL;
        end else if (ebrk_insn_i) begin
            cause_int  = 6'h03;   // reported only, never requests
        end else if (irq_any) begin
            cause_int  = {1'b1, irq_id};
            pc_mux_int = EXC_PC_IRQ;
        end
    end

    assign req_int = lsu_store_err_i | lsu_load_err_i | illegal_insn_i
                   | ecall_insn_i | irq_any;

    // ------------------------------------------------------------------
    // Handshake FSM. Outputs bypass the registers in IDLE so a request is
    // visible with zero latency; WAIT_ACK replays the frozen values.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cause_q  <= 6'h00;
            pc_mux_q <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (req_int) begin
                        cause_q  <= cause_int;
                        pc_mux_q <= pc_mux_int;
                        if (!ctrl.ack_i) state <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ctrl.ack_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ctrl.req_o        = 1'b0;
        ctrl.save_cause_o = 1'b0;
        ctrl.pc_mux_o     = 2'b00;
        cause_sel         = 6'h00;
        case (state)
            IDLE: begin
                ctrl.req_o        = req_int;
                ctrl.save_cause_o = req_int & ctrl.ack_i;
                ctrl.pc_mux_o     = pc_mux_int;
                cause_sel         = cause_int;
            end
            WAIT_ACK: begin
                ctrl.req_o        = 1'b1;
                ctrl.save_cause_o = ctrl.ack_i;
                ctrl.pc_mux_o     = pc_mux_q;
                cause_sel         = cause_q;
            end
            default: ;
        endcase
    end

    // ebreak overrides the reported cause in every state
    assign ctrl.cause_o      = ebrk_insn_i ? 6'h03 : cause_sel;
    assign ctrl.vec_pc_mux_o = ctrl.cause_o[4:0];

    assign ctrl.trap_o = dbg_settings_i[DBG_SETS_SSTE]
                       | (ecall_insn_i   & dbg_settings_i[DBG_SETS_ECALL])
                       | ((lsu_load_err_i | lsu_store_err_i) & dbg_settings_i[DBG_SETS_ELSU])
                       | (ebrk_insn_i    & dbg_settings_i[DBG_SETS_EBRK])
                       | (illegal_insn_i & dbg_settings_i[DBG_SETS_EILL])
                       | (irq_any        & dbg_settings_i[DBG_SETS_IRQ]);

endmodule

// File: tb/tb_riscv_exc_arbiter.sv
module tb_riscv_exc_arbiter;
    localparam int          N      = 8;
    localparam logic [31:0] EDGE_P = 32'h0000_0004;
`ifdef RISCV_EXC_EDGE_IRQ_EN
    localparam bit EDGE_ON = 1'b1;
`else
    localparam bit EDGE_ON = 1'b0;
`endif
    localparam logic [1:0] PC_ILL = 2'b00, PC_ECALL = 2'b01, PC_LOAD = 2'b10,
                           PC_STORE = 2'b10, PC_IRQ = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] irq_i = '0, irq_mask_i = '0, irq_pending_o;
    logic irq_enable_i = 1'b0;
    logic ebrk = 1'b0, ill = 1'b0, ecall = 1'b0, lderr = 1'b0, sterr = 1'b0;
    logic [5:0] dbg = '0;

    riscv_exc_arbiter_if ctrl_if ();

    riscv_exc_arbiter #(.NUM_IRQ(N), .IRQ_EDGE(EDGE_P), .DBG_SETS_W(6)) dut (
        .clk(clk), .rst(rst), .ctrl(ctrl_if.master),
        .irq_i(irq_i), .irq_mask_i(irq_mask_i), .irq_enable_i(irq_enable_i),
        .ebrk_insn_i(ebrk), .illegal_insn_i(ill), .ecall_insn_i(ecall),
        .lsu_load_err_i(lderr), .lsu_store_err_i(sterr),
        .irq_pending_o(irq_pending_o), .dbg_settings_i(dbg)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // reference model state: "holding" a frozen request, and edge pending bits
    bit         m_hold;
    logic [5:0] m_hcause;
    logic [1:0] m_hpc;
    logic [N-1:0] m_pend_e, m_prev;
    // next-state computed at the sampling point, applied at the clock edge
    bit         n_hold;
    logic [5:0] n_hcause;
    logic [1:0] n_hpc;
    logic [N-1:0] n_pend_e, n_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_check();
        logic [31:0] edge_v;
        logic [N-1:0] pend, eff;
        logic [5:0] c, cf, co;
        logic [1:0] pc, pcf;
        bit req_int, any, e_req, e_save, e_trap, hs;
        int id;
        edge_v = EDGE_P;
        for (int i = 0; i < N; i++)
            pend[i] = (EDGE_ON && edge_v[i]) ? m_pend_e[i] : irq_i[i];
        eff = pend & irq_mask_i & {N{irq_enable_i}};
        any = (eff != 0);
        id = 0;
        for (int i = N - 1; i >= 0; i--) if (eff[i]) id = i;
        // fresh arbitration from the priority rules
        cf = 6'h00; pcf = PC_ILL;
        if (sterr)      begin cf = 6'h07; pcf = PC_STORE; end
        else if (lderr) begin cf = 6'h05; pcf = PC_LOAD; end
        else if (ill)   begin cf = 6'h02; pcf = PC_ILL; end
        else if (ecall) begin cf = 6'h0B; pcf = PC_ECALL; end
        else if (ebrk)  begin cf = 6'h03; end
        else if (any)   begin cf = 6'h20 + 6'(id); pcf = PC_IRQ; end
        req_int = sterr | lderr | ill | ecall | any;
        if (m_hold) begin
            e_req = 1'b1; c = m_hcause; pc = m_hpc; e_save = ctrl_if.ack_i;
        end else begin
            e_req = req_int; c = cf; pc = pcf; e_save = req_int & ctrl_if.ack_i;
        end
        co = ebrk ? 6'h03 : c;
        e_trap = dbg[0] | (ecall & dbg[4]) | ((lderr | sterr) & dbg[2])
               | (ebrk & dbg[1]) | (ill & dbg[3]) | (any & dbg[5]);
        chk("req",     32'(ctrl_if.req_o),        32'(e_req));
        chk("save",    32'(ctrl_if.save_cause_o), 32'(e_save));
        chk("cause",   32'(ctrl_if.cause_o),      32'(co));
        chk("pc_mux",  32'(ctrl_if.pc_mux_o),     32'(pc));
        chk("vec",     32'(ctrl_if.vec_pc_mux_o), 32'(co[4:0]));
        chk("trap",    32'(ctrl_if.trap_o),       32'(e_trap));
        chk("pending", 32'(irq_pending_o),        32'(pend));
        // next state
        hs = e_req & ctrl_if.ack_i;
        if (rst) begin
            n_hold = 0; n_hcause = 0; n_hpc = 0; n_pend_e = 0; n_prev = 0;
        end else begin
            n_hold = m_hold ? !ctrl_if.ack_i : (req_int && !ctrl_if.ack_i);
            n_hcause = m_hcause; n_hpc = m_hpc;
            if (!m_hold && req_int) begin n_hcause = cf; n_hpc = pcf; end
            for (int i = 0; i < N; i++)
                n_pend_e[i] = (irq_i[i] & ~m_prev[i])
                            | (m_pend_e[i] & ~(hs && c[5] && (int'(c[4:0]) == i)));
            n_prev = irq_i;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_check();
    endtask

    task automatic adv();
        @(posedge clk);
        m_hold = n_hold; m_hcause = n_hcause; m_hpc = n_hpc;
        m_pend_e = n_pend_e; m_prev = n_prev;
        #1;
    endtask

    task automatic clr_in();
        irq_i = '0; irq_mask_i = '0; irq_enable_i = 0;
        ebrk = 0; ill = 0; ecall = 0; lderr = 0; sterr = 0; dbg = '0;
        ctrl_if.ack_i = 0;
    endtask

    initial begin
        clr_in();
        rst = 1;
        repeat (2) @(posedge clk);
        m_hold = 0; m_hcause = 0; m_hpc = 0; m_pend_e = 0; m_prev = 0;
        #1;
        // reset state
        settle();
        chk("rst_req", 32'(ctrl_if.req_o), 32'd0);
        chk("rst_cause", 32'(ctrl_if.cause_o), 32'd0);
        adv();
        rst = 0;

        // level IRQs 3 and 5, one-cycle handshake
        irq_enable_i = 1; irq_mask_i = 8'hFF; irq_i = 8'h28; ctrl_if.ack_i = 1;
        settle();
        chk("tp1_cause", 32'(ctrl_if.cause_o), 32'h23);
        chk("tp1_vec",   32'(ctrl_if.vec_pc_mux_o), 32'd3);
        chk("tp1_pc",    32'(ctrl_if.pc_mux_o), 32'(PC_IRQ));
        chk("tp1_save",  32'(ctrl_if.save_cause_o), 32'd1);
        adv();

        // store + illegal + irq0, held three cycles with inputs dropped
        clr_in(); irq_enable_i = 1; irq_mask_i = 8'hFF;
        ill = 1; sterr = 1; irq_i = 8'h01;
        settle();
        chk("tp2_cause", 32'(ctrl_if.cause_o), 32'h07);
        chk("tp2_pc",    32'(ctrl_if.pc_mux_o), 32'(PC_STORE));
        adv();
        ill = 0; sterr = 0; irq_i = 8'h00; lderr = 1;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) ctrl_if.ack_i = 1;
            settle();
            chk("tp2_hold", 32'(ctrl_if.cause_o), 32'h07);
            chk("tp2_req",  32'(ctrl_if.req_o), 32'd1);
            adv();
        end
        clr_in(); settle(); adv();

        // edge line 2 (level when the edge option is off)
        irq_enable_i = 1; irq_mask_i = 8'hFF;
        irq_i = 8'h04; settle(); adv();
        irq_i = 8'h00; ctrl_if.ack_i = 1;
        settle();
`ifdef RISCV_EXC_EDGE_IRQ_EN
        chk("tp3_pend",  32'(irq_pending_o[2]), 32'd1);
        chk("tp3_cause", 32'(ctrl_if.cause_o), 32'h22);
`endif
        adv();
        ctrl_if.ack_i = 0;
        settle(); adv();
        irq_i = 8'h04; settle(); adv();          // second pulse
        irq_i = 8'h00; settle(); adv();          // request, no ack -> hold
        irq_i = 8'h04; ctrl_if.ack_i = 1;        // new edge on the ack cycle
        settle(); adv();
        irq_i = 8'h00; ctrl_if.ack_i = 0;
        settle();
`ifdef RISCV_EXC_EDGE_IRQ_EN
        chk("tp3_setwins", 32'(irq_pending_o[2]), 32'd1);
`endif
        ctrl_if.ack_i = 1; settle(); adv();
        clr_in(); settle(); adv();

        // masked line 5
        irq_enable_i = 1; irq_mask_i = 8'hDF; irq_i = 8'h20; dbg = 6'h20;
        settle();
        chk("tp4_req",  32'(ctrl_if.req_o), 32'd0);
        chk("tp4_trap", 32'(ctrl_if.trap_o), 32'd0);
        adv();
        irq_mask_i = 8'hFF; ctrl_if.ack_i = 1;
        settle();
        chk("tp4_cause", 32'(ctrl_if.cause_o), 32'h25);
        adv();

        // reset while waiting for ack
        clr_in(); irq_enable_i = 1; irq_mask_i = 8'hFF; irq_i = 8'h01;
        settle(); adv();
        irq_i = 8'h00; settle(); adv();
        rst = 1; settle(); adv();
        rst = 0;
        settle();
        chk("tp5_req",   32'(ctrl_if.req_o), 32'd0);
        chk("tp5_cause", 32'(ctrl_if.cause_o), 32'd0);
        chk("tp5_pend",  32'(irq_pending_o), 32'd0);
        adv();

        // ebreak alone
        clr_in(); ebrk = 1; dbg = 6'h02;
        settle();
        chk("tp6_req",   32'(ctrl_if.req_o), 32'd0);
        chk("tp6_cause", 32'(ctrl_if.cause_o), 32'h03);
        chk("tp6_trap",  32'(ctrl_if.trap_o), 32'd1);
        adv();
        clr_in();

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            irq_i        = N'($urandom);
            irq_mask_i   = N'($urandom | $urandom);
            irq_enable_i = ($urandom_range(0, 3) != 0);
            sterr        = ($urandom_range(0, 9) == 0);
            lderr        = ($urandom_range(0, 9) == 0);
            ill          = ($urandom_range(0, 9) == 0);
            ecall        = ($urandom_range(0, 9) == 0);
            dbg          = 6'($urandom) & 6'h3E;
            ctrl_if.ack_i = ($urandom_range(0, 2) == 0);
            rst          = ($urandom_range(0, 49) == 0);
            settle();
            adv();
        end
        rst = 0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/riscv_exc_arbiter.md
# riscv_exc_arbiter

Parametrised exception/interrupt arbiter for the RI5CY pipeline, sitting between the ID-stage decoder/LSU error lines, the CSR block and the main controller. It generalises the exception controller to a configurable number of interrupt lines with per-line masking and optional edge-triggered pending latches. It prioritises synchronous exceptions over interrupts and holds a stable cause and PC-mux selection through a request/acknowledge handshake. It also raises debug traps per the debug settings vector.

## Interface
- NUM_IRQ, 32, number of interrupt lines, 1..32; IRQ ids are 0..NUM_IRQ-1
- IRQ_EDGE, 32'h0, bit i=1 makes line i edge-triggered (rising); only honoured with the macro defined
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- req_o  out  1  exception/IRQ request to controller
- ack_i  in  1  controller accepts request
- trap_o  out  1  debug trap request
- pc_mux_o  out  2  exception PC select (riscv_defines EXC_PC_*)
- vec_pc_mux_o  out  5  vectored IRQ handler index = cause_o[4:0]
- irq_i  in  NUM_IRQ  interrupt lines
- irq_mask_i  in  NUM_IRQ  per-line enable, 1 = enabled
- irq_enable_i  in  1  global interrupt enable (CSR)
- ebrk_insn_i, illegal_insn_i, ecall_insn_i  in  1 each  decoder events
- lsu_load_err_i, lsu_store_err_i  in  1 each  LSU bus errors
- cause_o  out  6  cause to CSR; bit5 = interrupt, [4:0] = code/id
- save_cause_o  out  1  CSR write strobe for cause_o
- irq_pending_o  out  NUM_IRQ  current pending vector (debug/CSR visibility)
- dbg_settings_i  in  DBG_SETS_W  debug settings (DBG_SETS_SSTE/ECALL/ELSU/EBRK/EILL/IRQ)

## Operation
- Pending: level line i pend[i] = irq_i[i]; edge line sets pend_q[i] on irq_i[i] & ~irq_d[i]; cleared on the handshake cycle (req_o & ack_i) whose captured cause is interrupt id i. Set and clear in the same cycle: set wins.
- Effective IRQ vector eff = pend & irq_mask_i & {NUM_IRQ{irq_enable_i}}; selected id = lowest set index.
- Priority (highest first): store err (cause 6'h07, EXC_PC_STORE), load err (6'h05, EXC_PC_LOAD), illegal (6'h02, EXC_PC_ILLINSN), ecall (6'h0B, EXC_PC_ECALL), ebreak (6'h03, cause only, no request), IRQ ({1'b1,id}, EXC_PC_IRQ).
- req_int = any of store/load/illegal/ecall | (|eff).
- FSM IDLE: req_o = req_int; cause/pc_mux bypassed combinationally and captured into cause_q/pc_mux_q; if ack_i same cycle -> save_cause_o=1, stay IDLE, else -> WAIT_ACK.
- FSM WAIT_ACK: req_o = 1; outputs driven from captured registers; input changes (IRQ drop, new exception) ignored; ack_i -> save_cause_o=1, -> IDLE.
- ebrk_insn_i forces cause_o = 6'h03 in any state (bypass), no req.
- trap_o = SSTE | ecall&ECALL | (load|store err)&ELSU | ebrk&EBRK | illegal&EILL | (|eff)&IRQ.
- Illegal FSM encoding -> IDLE.

## Timing
- Reset (rst=1 at a clk edge): FSM IDLE, cause_q=0, pc_mux_q=0, pend_q=0, irq_d=0; with inputs low: req_o=0, save_cause_o=0, cause_o=0, pc_mux_o=0, trap_o=0 (unless SSTE).
- Level IRQ/exception -> req_o same cycle (0 latency); edge IRQ -> req_o 1 cycle after rising edge (pending register).
- Ack in same cycle as first request: one-cycle handshake, no WAIT_ACK.
- rst during WAIT_ACK: request dropped, pending edges lost, IDLE next cycle.
- Held request never drops until ack_i; cause_o/pc_mux_o stable throughout.

## Configuration
- RISCV_EXC_EDGE_IRQ_EN defined: IRQ_EDGE honoured; edge detect and pend_q registers built.
- Not defined: all lines level-sensitive, IRQ_EDGE ignored, no pend_q/irq_d flops; irq_pending_o = irq_i.

## Test plan
- NUM_IRQ=8, irq_enable_i=1, mask=8'hFF, irq_i=8'h28, ack_i=1 -> req_o=1, cause_o=6'h23, vec_pc_mux_o=5'd3, pc_mux_o=EXC_PC_IRQ, save_cause_o=1 same cycle.
- illegal_insn_i and lsu_store_err_i together with irq_i[0] -> cause_o=6'h07, pc_mux_o=EXC_PC_STORE; ack after 3 cycles with inputs dropped -> cause held 6'h07 until ack.
- Macro on, IRQ_EDGE=8'h04: 1-cycle pulse on irq_i[2] -> pending[2]=1 next cycle, req_o=1 cause 6'h22; ack clears pending[2]; new pulse on ack cycle -> pending stays 1.
- irq_mask_i[5]=0, irq_i=8'h20 -> req_o=0, trap_o=0 with DBG_SETS_IRQ set; unmask -> req_o=1, cause 6'h25.
- rst asserted in WAIT_ACK -> next cycle req_o=0, cause_o=0, pending cleared.
- ebrk_insn_i alone with DBG_SETS_EBRK -> req_o=0, cause_o=6'h03, trap_o=1.
